// File: rtl/irq_ctl_pkg.sv
// Shared definitions for the interrupt controller: CSR register offsets
// within the selected page and the layout of the VECTOR read word.
package irq_ctl_pkg;

   localparam logic [3:0] OFF_PENDING = 4'h0;
   localparam logic [3:0] OFF_MASK    = 4'h1;
   localparam logic [3:0] OFF_STATUS  = 4'h2;
   localparam logic [3:0] OFF_VECTOR  = 4'h3;
   localparam logic [3:0] OFF_SOFTSET = 4'h4;

   localparam int VEC_VALID_BIT = 31;
   localparam int VEC_IDX_W     = 5;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports the lowest-numbered set request
// bit. Only instantiated when IRQ_CTL_VECTOR_EN is defined.
module irq_prio_enc
   import irq_ctl_pkg::*;
#(
   parameter int nirq = 8
) (
   input  logic [nirq-1:0]      req,
   output logic                 valid,
   output logic [VEC_IDX_W-1:0] idx
);

   // Scan from the top down so the last hit, the lowest index, wins.
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = nirq - 1; i >= 0; i--) begin
         if (req[i]) idx = VEC_IDX_W'(i);
      end
   end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: latches one-cycle interrupt pulses into PENDING,
// gates them with MASK and raises a registered level request to the CPU.
// CSR page selected by csr_a[13:10] == csr_addr, register by csr_a[3:0].
// Build option: define IRQ_CTL_VECTOR_EN to add the VECTOR priority encoder;
// without it VECTOR reads zero.
module irq_ctl
   import irq_ctl_pkg::*;
#(
   parameter logic [3:0] csr_addr = 4'h1,
   parameter int         nirq     = 8
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic [nirq-1:0] irq_in,
   input  logic [13:0]     csr_a,
   input  logic            csr_we,
   input  logic [31:0]     csr_di,
   output logic [31:0]     csr_do,
   output logic            cpu_irq
);

   logic            csr_sel;
   logic            wr_en;
   logic [3:0]      reg_off;
   logic [nirq-1:0] wr_bits;
   logic [nirq-1:0] pending_q;
   logic [nirq-1:0] pending_d;
   logic [nirq-1:0] mask_q;
   logic [nirq-1:0] mask_d;
   logic [nirq-1:0] status;
   logic [31:0]     vector_word;
   logic [31:0]     rd_data;
   logic            unused_csr;

   assign csr_sel = (csr_a[13:10] == csr_addr);
   assign wr_en   = csr_sel & csr_we;
   assign reg_off = csr_a[3:0];
   assign wr_bits = csr_di[nirq-1:0];
   assign status  = pending_q & mask_q;

   // Address bits between page select and offset, and data bits above nirq,
   // are don't-care.
   assign unused_csr = ^{csr_a[9:4], csr_di};

`ifdef IRQ_CTL_VECTOR_EN
   logic                 vec_valid;
   logic [VEC_IDX_W-1:0] vec_idx;

   irq_prio_enc #(
      .nirq (nirq)
   ) u_prio_enc (
      .req   (status),
      .valid (vec_valid),
      .idx   (vec_idx)
   );

   // Assemble VECTOR: valid flag on top, source index in the low bits.
   always_comb begin
      vector_word                    = '0;
      vector_word[VEC_VALID_BIT]     = vec_valid;
      vector_word[VEC_IDX_W-1:0]     = vec_idx;
   end
`else
   assign vector_word = '0;
`endif

   // Next register values; hardware pulses are ORed in last so a set always
   // beats a same-cycle software clear.
   always_comb begin
      pending_d = pending_q | irq_in;
      mask_d    = mask_q;
      if (wr_en) begin
         case (reg_off)
            OFF_PENDING: pending_d = (pending_q & ~wr_bits) | irq_in;
            OFF_MASK:    mask_d    = wr_bits;
            OFF_SOFTSET: pending_d = pending_q | wr_bits | irq_in;
            default:     ;
         endcase
      end
   end

   // Read mux works from the current register values, so a read during a
   // write to the same register returns the pre-write contents.
   always_comb begin
      rd_data = '0;
      if (csr_sel) begin
         case (reg_off)
            OFF_PENDING: rd_data = 32'(pending_q);
            OFF_MASK:    rd_data = 32'(mask_q);
            OFF_STATUS:  rd_data = 32'(status);
            OFF_VECTOR:  rd_data = vector_word;
            default:     rd_data = '0;
         endcase
      end
   end

   // Register state, read data and the CPU request.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pending_q <= '0;
         mask_q    <= '0;
         csr_do    <= '0;
         cpu_irq   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         csr_do    <= rd_data;
         cpu_irq   <= |status;
      end
   end

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl (nirq=8, page 1). Each table row drives one
// cycle of inputs and states csr_do / cpu_irq expected just after the edge.
module tb_irq_ctl;

   localparam logic [3:0] PAGE = 4'h1;

`ifdef IRQ_CTL_VECTOR_EN
   localparam logic [31:0] VEC_88 = 32'h8000_0003;
   localparam logic [31:0] VEC_01 = 32'h8000_0000;
`else
   localparam logic [31:0] VEC_88 = 32'h0000_0000;
   localparam logic [31:0] VEC_01 = 32'h0000_0000;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [7:0]  irq_in;
   logic [13:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;
   logic [31:0] csr_do;
   logic        cpu_irq;

   int total = 0;
   int bad   = 0;

   irq_ctl #(
      .csr_addr (PAGE),
      .nirq     (8)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .irq_in    (irq_in),
      .csr_a     (csr_a),
      .csr_we    (csr_we),
      .csr_di    (csr_di),
      .csr_do    (csr_do),
      .cpu_irq   (cpu_irq)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic        sel;
      logic        we;
      logic [3:0]  off;
      logic [31:0] di;
      logic [7:0]  irq;
      logic [31:0] exp_do;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic sel, logic we, logic [3:0] off,
                               logic [31:0] di, logic [7:0] irq,
                               logic [31:0] exp_do, logic exp_irq);
      vec_t v;
      v.sel = sel; v.we = we; v.off = off; v.di = di; v.irq = irq;
      v.exp_do = exp_do; v.exp_irq = exp_irq;
      return v;
   endfunction

   task automatic drive(logic sel, logic we, logic [3:0] off,
                        logic [31:0] di, logic [7:0] irq);
      csr_a  = {(sel ? PAGE : 4'h2), 6'h2A, off};
      csr_we = we;
      csr_di = di;
      irq_in = irq;
   endtask

   task automatic check(string name, logic [31:0] exp_do, logic exp_irq);
      total++;
      if (csr_do !== exp_do) begin
         bad++;
         $display("FAIL %s csr_do got=%h want=%h", name, csr_do, exp_do);
      end
      total++;
      if (cpu_irq !== exp_irq) begin
         bad++;
         $display("FAIL %s cpu_irq got=%b want=%b", name, cpu_irq, exp_irq);
      end
   endtask

   task automatic cycle(string name, logic sel, logic we, logic [3:0] off,
                        logic [31:0] di, logic [7:0] irq,
                        logic [31:0] exp_do, logic exp_irq);
      drive(sel, we, off, di, irq);
      @(posedge sys_clk);
      #1;
      check(name, exp_do, exp_irq);
   endtask

   initial begin
      // sel we off   di            irq    exp_do        exp_irq
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,        8'h00, 32'h0,  0));
      vecs.push_back(mk(1, 1, 4'h1, 32'h01,       8'h00, 32'h0,  0));
      vecs.push_back(mk(1, 0, 4'h1, 32'h0,        8'h01, 32'h01, 0));
      vecs.push_back(mk(1, 0, 4'h2, 32'h0,        8'h00, 32'h01, 1));
      vecs.push_back(mk(1, 1, 4'h0, 32'h01,       8'h00, 32'h01, 1));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,        8'h00, 32'h0,  0));
      vecs.push_back(mk(1, 1, 4'h1, 32'h00,       8'h00, 32'h01, 0));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,        8'h04, 32'h0,  0));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,        8'h00, 32'h04, 0));
      vecs.push_back(mk(1, 1, 4'h1, 32'h04,       8'h00, 32'h0,  0));
      vecs.push_back(mk(1, 0, 4'h2, 32'h0,        8'h00, 32'h04, 1));
      vecs.push_back(mk(1, 1, 4'h0, 32'h04,       8'h00, 32'h04, 1));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,        8'h02, 32'h0,  0));
      vecs.push_back(mk(1, 1, 4'h1, 32'h02,       8'h00, 32'h04, 0));
      vecs.push_back(mk(1, 1, 4'h0, 32'h02,       8'h02, 32'h02, 1));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,        8'h00, 32'h02, 1));
      vecs.push_back(mk(1, 1, 4'h0, 32'h02,       8'h00, 32'h02, 1));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,        8'h00, 32'h0,  0));
      vecs.push_back(mk(1, 1, 4'h1, 32'hFFFFFFFF, 8'h00, 32'h02, 0));
      vecs.push_back(mk(1, 0, 4'h1, 32'h0,        8'h00, 32'hFF, 0));
      vecs.push_back(mk(1, 1, 4'h4, 32'h80,       8'h08, 32'h0,  0));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,        8'h00, 32'h88, 1));
      vecs.push_back(mk(1, 0, 4'h2, 32'h0,        8'h00, 32'h88, 1));
      vecs.push_back(mk(1, 0, 4'h3, 32'h0,        8'h00, VEC_88, 1));
      vecs.push_back(mk(1, 0, 4'h4, 32'h0,        8'h00, 32'h0,  1));
      vecs.push_back(mk(0, 0, 4'h0, 32'h0,        8'h00, 32'h0,  1));
      vecs.push_back(mk(0, 1, 4'h0, 32'hFF,       8'h00, 32'h0,  1));
      vecs.push_back(mk(1, 0, 4'h7, 32'h0,        8'h00, 32'h0,  1));
      vecs.push_back(mk(1, 1, 4'h7, 32'hFF,       8'h00, 32'h0,  1));
      vecs.push_back(mk(1, 1, 4'h2, 32'h00,       8'h00, 32'h88, 1));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,        8'h00, 32'h88, 1));
      vecs.push_back(mk(1, 1, 4'h0, 32'h88,       8'h00, 32'h88, 1));
      vecs.push_back(mk(1, 0, 4'h3, 32'h0,        8'h00, 32'h0,  0));
      vecs.push_back(mk(1, 1, 4'h1, 32'h10,       8'h00, 32'hFF, 0));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,        8'h10, 32'h0,  0));
      vecs.push_back(mk(1, 0, 4'h2, 32'h0,        8'h00, 32'h10, 1));

      sys_rst_n = 1'b0;
      drive(1, 0, 4'h0, 32'h0, 8'h00);
      #1;
      check("reset_init", 32'h0, 1'b0);
      repeat (2) @(posedge sys_clk);
      #3 sys_rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         cycle($sformatf("vec%0d", i), vecs[i].sel, vecs[i].we, vecs[i].off,
               vecs[i].di, vecs[i].irq, vecs[i].exp_do, vecs[i].exp_irq);
      end

      // Asynchronous reset mid-operation with PENDING=MASK=0x10 live.
      drive(1, 0, 4'h0, 32'h0, 8'h00);
      #2 sys_rst_n = 1'b0;
      #1;
      check("async_rst", 32'h0, 1'b0);
      drive(1, 0, 4'h0, 32'h0, 8'hFF);
      @(posedge sys_clk);
      #1;
      check("rst_hold", 32'h0, 1'b0);
      drive(1, 0, 4'h0, 32'h0, 8'h00);
      #3 sys_rst_n = 1'b1;

      cycle("post_rst_pend", 1, 0, 4'h0, 32'h0, 8'h01, 32'h0,  1'b0);
      cycle("post_rst_mask", 1, 0, 4'h1, 32'h0, 8'h00, 32'h0,  1'b0);
      cycle("first_capture", 1, 0, 4'h0, 32'h0, 8'h00, 32'h01, 1'b0);
      cycle("unsel_read",    0, 0, 4'h0, 32'h0, 8'h00, 32'h0,  1'b0);
      cycle("mask_all",      1, 1, 4'h1, 32'hFF, 8'h00, 32'h0, 1'b0);
      cycle("vector_bit0",   1, 0, 4'h3, 32'h0, 8'h00, VEC_01, 1'b1);

      drive(1, 0, 4'h0, 32'h0, 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/irq_ctl.md
IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 Parameter csr_addr, default 4'h1: CSR page selected when csr_a[13:10] equals it.
REQ-002 Parameter nirq, default 8, legal 1..32: number of interrupt sources.
REQ-003 sys_clk  in  1  single system clock; all logic on its rising edge.
REQ-004 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 irq_in  in  nirq  one-cycle interrupt pulses from sysctl (gpio_irq, timer0_irq, timer1_irq) and other cores, already in sys_clk domain.
REQ-006 csr_a  in  14  CSR address.
REQ-007 csr_we  in  1  CSR write strobe.
REQ-008 csr_di  in  32  CSR write data.
REQ-009 csr_do  out  32  CSR read data, registered.
REQ-010 cpu_irq  out  1  level interrupt request to CPU, registered.

Function
REQ-011 Registers, csr_a[3:0]: 0 PENDING (read; write-1-to-clear), 1 MASK (read/write, 1 = enabled), 2 STATUS = PENDING & MASK (read-only), 3 VECTOR (read-only, see Configuration), 4 SOFTSET (write-1-to-set PENDING; reads zero); other offsets read zero, writes ignored.
REQ-012 Pending bit i SHALL set on the first rising edge where irq_in[i]=1, and stay set until cleared by software.
REQ-013 Same-cycle irq_in[i]=1 and PENDING write-1 on bit i: bit SHALL remain set (set wins).
REQ-014 Same-cycle SOFTSET and hardware pulse on any bits: both sets SHALL apply (OR).
REQ-015 cpu_irq SHALL equal the registered value of |(PENDING & MASK): high one cycle after PENDING/MASK change, so pulse at edge N gives PENDING at N, cpu_irq at N+1.
REQ-016 Clearing the last enabled pending bit or masking it SHALL drop cpu_irq one edge after the register update.
REQ-017 Read latency one cycle: csr_do reflects register values in the cycle after the address; csr_do SHALL be zero in any cycle after an unselected address.
REQ-018 Read of a register during a same-cycle write to it SHALL return the pre-write value.
REQ-019 Bits [31:nirq] of csr_do SHALL read zero; corresponding csr_di bits ignored.
REQ-020 Writes only take effect when csr_selected and csr_we are both 1.

Reset
REQ-021 On sys_rst_n=0, immediately and independent of sys_clk: PENDING=0, MASK=0, csr_do=0, cpu_irq=0.
REQ-022 Pulses during reset SHALL be lost; first capture on the first edge after deassertion.
REQ-023 Reset asserted mid-operation SHALL discard all pending state.

Configuration
REQ-024 Macro IRQ_CTL_VECTOR_EN: when defined, VECTOR reads {valid at bit 31, zeros, index of lowest-numbered set bit of STATUS at bits [4:0]}; valid=0 and index=0 when STATUS is zero.
REQ-025 Without IRQ_CTL_VECTOR_EN: VECTOR reads zero, no priority encoder logic present; all other behaviour identical.

Structure
REQ-026 Shared package irq_ctl_pkg SHALL hold register offset constants (PENDING, MASK, STATUS, VECTOR, SOFTSET) and the VECTOR valid-bit position.
REQ-027 Priority encoder SHALL be a sub-module irq_prio_enc (nirq-wide input, valid plus 5-bit index output, combinational), instantiated only under IRQ_CTL_VECTOR_EN.

Verification
REQ-028 MASK=0x01, pulse irq_in=0x01 at edge N -> PENDING=0x01 after N, cpu_irq=1 after N+1; read STATUS returns 0x01.
REQ-029 MASK=0x00, pulse irq_in=0x04 -> PENDING reads 0x04, cpu_irq stays 0; then write MASK=0x04 -> cpu_irq=1 one edge later.
REQ-030 PENDING=0x02, same cycle write PENDING=0x02 and irq_in=0x02 -> PENDING reads 0x02; next write 0x02 alone -> reads 0x00, cpu_irq falls one edge later.
REQ-031 MASK=0xFF, SOFTSET write 0x80 with irq_in=0x08 same cycle -> PENDING=0x88; with IRQ_CTL_VECTOR_EN VECTOR reads 0x80000003; without it reads 0x00000000.
REQ-032 PENDING=0x10, MASK=0x10, assert sys_rst_n=0 between edges -> cpu_irq, csr_do, PENDING, MASK zero without a clock edge; unselected csr_a read returns 0.
